hazard_detect: RTL and testbench
================================

HAZARD_DETECT -- requirements
Module: hazard_detect

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-index width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall-counter width (used only with HAZARD_PERF_CNT_EN).
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port id_valid  input  1  the ID stage holds a real instruction.
REQ-006 SHALL have port id_op  input  7  opcode of the ID instruction.
REQ-007 SHALL have ports id_rs1, id_rs2, id_rd  input  REG_AW each  register indices of the ID instruction.
REQ-008 SHALL have port ex_redirect  input  1  a branch or jump resolved taken in EX this cycle.
REQ-009 SHALL have port stall  output  1  hold the PC and the IF/ID register; combinational.
REQ-010 SHALL have port flush  output  1  kill the IF/ID contents; combinational, equal to ex_redirect.
REQ-011 SHALL have ports is_hazard1, is_hazard2  output  1 each  registered; they describe the instruction now in EX.
REQ-012 SHALL have ports hazard_reg1, hazard_reg2  output  3 each  registered forwarding codes; the encoding is defined in REQ-017 and REQ-018.
REQ-013 SHALL have port stall_cnt  output  CNT_W  count of load-use stall cycles; present only with HAZARD_PERF_CNT_EN.

Function
REQ-014 SHALL decode from id_op whether the ID instruction uses rs1 and uses rs2, and whether it writes rd.
- Uses rs1: JALR, LOAD, OP-IMM, BRANCH, STORE, OP.
- Uses rs2: BRANCH, STORE, OP.
- Writes rd: every opcode except BRANCH and STORE, and only when rd != 0.
REQ-015 SHALL keep two tracking slots, EX and MEM, each holding {rd, wen, is_load}.
REQ-016 SHALL advance the slots every cycle as follows.
- MEM takes the previous EX contents.
- EX takes the ID instruction's fields, or a bubble (wen=0) when stall, flush, or !id_valid.
REQ-017 SHALL compute the EX-match code hazard_reg1 before the slots advance.
- 1 if rs1 is used and equals EX.rd with EX.wen set.
- Otherwise 2 if rs2 is used and equals EX.rd with EX.wen set.
- Otherwise 0.
- is_hazard1 = (code != 0).
REQ-018 SHALL compute the MEM-match code hazard_reg2 the same way against the MEM slot: 3 for rs1, 4 for rs2, 0 for none; is_hazard2 = (code != 0).
REQ-019 SHALL register both codes and both flags into EX-aligned outputs, so they reach the EX stage with one-cycle latency alongside the instruction; a bubble registers all four as 0.
REQ-020 SHALL assert stall combinationally when all of the following hold: id_valid, EX.is_load, EX.wen, and a used source register matches EX.rd.
REQ-021 SHALL implement a two-state FSM.
- IDLE -> STALL when stall is asserted and ex_redirect is low.
- STALL -> IDLE unconditionally.
- A stall therefore lasts exactly one cycle, after which the load sits in MEM and produces code 3 or 4.
REQ-022 SHALL give ex_redirect priority over stall: when both are true in a cycle, stall=0, the EX slot takes a bubble, and the FSM goes to IDLE.
REQ-023 SHALL never report a hazard on register 0 and SHALL ignore the source fields of opcodes that do not use them.

Reset
REQ-024 SHALL, while rst_n=0, clear both slots (wen=0, is_load=0), put the FSM in IDLE, and drive every registered output to 0.
REQ-025 SHALL produce stall=0 and flush=ex_redirect during and immediately after reset; reset asserted mid-stall discards the stall.

Configuration
REQ-026 SHALL, when HAZARD_PERF_CNT_EN is defined, increment stall_cnt by 1 on each cycle with stall=1, saturating at all-ones.
REQ-027 SHALL, when HAZARD_PERF_CNT_EN is undefined, omit both the stall_cnt port and its register; all other behaviour is identical.

Structure
REQ-028 SHALL take opcode constants (LOAD, JAL, JALR, BRANCH, STORE, OP, OP-IMM, LUI, AUIPC) and the forwarding codes 0 to 4 from the shared defines package.
REQ-029 SHALL instantiate sub-module src_match twice, once per slot; it maps (rs1, rs2, use1, use2, rd, wen) to a 3-bit code with a base-offset parameter (1 or 3).

Verification
REQ-030 SHALL cover: `add x5,x1,x2` then `sub x6,x5,x3` -> next cycle is_hazard1=1, hazard_reg1=1, stall=0.
REQ-031 SHALL cover: `add x5`, a nop, then `or x7,x4,x5` -> hazard_reg2=4, is_hazard2=1, hazard_reg1=0.
REQ-032 SHALL cover: `lw x8,0(x1)` then `add x9,x8,x2` -> stall=1 for exactly one cycle, an EX bubble, then hazard_reg2=3.
REQ-033 SHALL cover: `lw x8`, `beq x8,x0` with ex_redirect=1 in the same cycle -> stall=0, flush=1, EX bubble.
REQ-034 SHALL cover: `addi x0,x0,1` then `add x1,x0,x0` -> no hazard; `lui x3` then `add x3` -> hazard_reg1=1.
REQ-035 SHALL cover: with HAZARD_PERF_CNT_EN and CNT_W=2, four load-use stalls -> stall_cnt=3, saturated.

Source files
------------

// File: rtl/hazard_detect_pkg.sv
// Shared defines for the ID-stage hazard detector: RV32 major opcodes,
// forwarding codes, FSM state type and opcode-class decode helpers.
package hazard_detect_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Forwarding codes seen by the EX stage
    localparam logic [2:0] FWD_NONE    = 3'd0;
    localparam logic [2:0] FWD_EX_RS1  = 3'd1;
    localparam logic [2:0] FWD_EX_RS2  = 3'd2;
    localparam logic [2:0] FWD_MEM_RS1 = 3'd3;
    localparam logic [2:0] FWD_MEM_RS2 = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

    function automatic logic op_uses_rs1(input logic [6:0] op);
        return (op == OPC_JALR) || (op == OPC_LOAD) || (op == OPC_OP_IMM) ||
               (op == OPC_BRANCH) || (op == OPC_STORE) || (op == OPC_OP);
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OPC_BRANCH) || (op == OPC_STORE) || (op == OPC_OP);
    endfunction

    // Branches and stores are the only classes without a destination
    function automatic logic op_writes_rd(input logic [6:0] op);
        return (op != OPC_BRANCH) && (op != OPC_STORE);
    endfunction

endpackage

// File: rtl/hazard_detect_src_match.sv
// Source-vs-destination comparator for one tracking slot. Produces BASE when
// rs1 matches, BASE+1 when only rs2 matches, FWD_NONE otherwise. x0 never
// matches because it is never a real producer.
module src_match
    import hazard_detect_pkg::*;
#(
    parameter int         REG_AW = 5,
    parameter logic [2:0] BASE   = FWD_EX_RS1
) (
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use1,
    input  logic              use2,
    input  logic [REG_AW-1:0] rd,
    input  logic              wen,
    output logic [2:0]        code
);

    // rs1 takes priority over rs2 when both hit the same producer
    always_comb begin
        code = FWD_NONE;
        if (wen && (rd != '0)) begin
            if (use1 && (rs1 == rd)) begin
                code = BASE;
            end else if (use2 && (rs2 == rd)) begin
                code = BASE + 3'd1;
            end
        end
    end

endmodule

// File: rtl/hazard_detect.sv
// ID-stage hazard detector: tracks the destinations of the instructions in
// EX and MEM, produces registered forwarding codes for EX, a one-cycle
// load-use stall and the redirect flush.
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating
// stall_cnt performance counter port.
module hazard_detect
    import hazard_detect_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_op,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush,
    output logic              is_hazard1,
    output logic              is_hazard2,
    output logic [2:0]        hazard_reg1,
    output logic [2:0]        hazard_reg2
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    logic              use1;
    logic              use2;
    logic              wr_rd;
    logic              is_ld;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wen;
    logic              ex_load;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_wen;
    logic              mem_load;
    logic [2:0]        code_ex;
    logic [2:0]        code_mem;
    logic              load_use;
    logic              bubble;
    hz_state_t         state;
    hz_state_t         state_nxt;

    // Opcode-class decode of the ID instruction
    always_comb begin
        use1  = op_uses_rs1(id_op);
        use2  = op_uses_rs2(id_op);
        wr_rd = op_writes_rd(id_op) && (id_rd != '0);
        is_ld = (id_op == OPC_LOAD);
    end

    src_match #(.REG_AW(REG_AW), .BASE(FWD_EX_RS1)) u_match_ex (
        .rs1  (id_rs1),
        .rs2  (id_rs2),
        .use1 (use1),
        .use2 (use2),
        .rd   (ex_rd),
        .wen  (ex_wen),
        .code (code_ex)
    );

    src_match #(.REG_AW(REG_AW), .BASE(FWD_MEM_RS1)) u_match_mem (
        .rs1  (id_rs1),
        .rs2  (id_rs2),
        .use1 (use1),
        .use2 (use2),
        .rd   (mem_rd),
        .wen  (mem_wen),
        .code (code_mem)
    );

    // A load in EX cannot forward yet; any used source matching it must wait
    assign load_use = id_valid && ex_load && (code_ex != FWD_NONE);
    assign flush    = ex_redirect;
    assign bubble   = stall || ex_redirect || !id_valid;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a stall always lasts exactly one cycle
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = (load_use && !ex_redirect) ? ST_STALL : ST_IDLE;
            ST_STALL: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: redirect overrides the stall
    always_comb begin
        stall = 1'b0;
        if (state == ST_IDLE) begin
            stall = load_use && !ex_redirect;
        end
    end

    // EX/MEM tracking slots; EX takes a bubble when ID does not advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd    <= '0;
            ex_wen   <= 1'b0;
            ex_load  <= 1'b0;
            mem_rd   <= '0;
            mem_wen  <= 1'b0;
            mem_load <= 1'b0;
        end else begin
            mem_rd   <= ex_rd;
            mem_wen  <= ex_wen;
            mem_load <= ex_load;
            if (bubble) begin
                ex_rd   <= '0;
                ex_wen  <= 1'b0;
                ex_load <= 1'b0;
            end else begin
                ex_rd   <= id_rd;
                ex_wen  <= wr_rd;
                ex_load <= is_ld;
            end
        end
    end

    // Forwarding codes travel into EX together with the instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_reg1 <= FWD_NONE;
            hazard_reg2 <= FWD_NONE;
            is_hazard1  <= 1'b0;
            is_hazard2  <= 1'b0;
        end else if (bubble) begin
            hazard_reg1 <= FWD_NONE;
            hazard_reg2 <= FWD_NONE;
            is_hazard1  <= 1'b0;
            is_hazard2  <= 1'b0;
        end else begin
            hazard_reg1 <= code_ex;
            hazard_reg2 <= code_mem;
            is_hazard1  <= (code_ex != FWD_NONE);
            is_hazard2  <= (code_mem != FWD_NONE);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating count of load-use stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Randomized self-checking bench for hazard_detect with a behavioural model
// of the pipeline's in-flight destinations. Define HAZARD_PERF_CNT_EN to
// also check the stall counter (instantiated with CNT_W=2).
module tb_hazard_detect;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BADOP  = 7'b1111111;

    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
        logic       ld;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_op;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       ex_redirect;
    logic       stall;
    logic       flush;
    logic       is_hazard1;
    logic       is_hazard2;
    logic [2:0] hazard_reg1;
    logic [2:0] hazard_reg2;
`ifdef HAZARD_PERF_CNT_EN
    logic [1:0] stall_cnt;
`endif

    int    n_chk  = 0;
    int    n_fail = 0;
    slot_t m_ex;
    slot_t m_mem;
    int    m_cnt;
    logic  m_stall;
    logic  obs_stall;

    hazard_detect #(.REG_AW(5), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_op       (id_op),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .ex_redirect (ex_redirect),
        .stall       (stall),
        .flush       (flush),
        .is_hazard1  (is_hazard1),
        .is_hazard2  (is_hazard2),
        .hazard_reg1 (hazard_reg1),
        .hazard_reg2 (hazard_reg2)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic uses1(input logic [6:0] op);
        return op inside {JALR, LOAD, OPIMM, BRANCH, STORE, OP};
    endfunction

    function automatic logic uses2(input logic [6:0] op);
        return op inside {BRANCH, STORE, OP};
    endfunction

    function automatic logic writes(input logic [6:0] op, input logic [4:0] rd);
        return !(op inside {BRANCH, STORE}) && (rd != 5'd0);
    endfunction

    // Forwarding code of an ID instruction against one in-flight producer
    function automatic logic [2:0] fwd_code(input logic [6:0] op, input logic [4:0] r1,
                                            input logic [4:0] r2, input slot_t s,
                                            input logic [2:0] base);
        if (s.wen && uses1(op) && r1 == s.rd && r1 != 5'd0) return base;
        if (s.wen && uses2(op) && r2 == s.rd && r2 != 5'd0) return base + 3'd1;
        return 3'd0;
    endfunction

    // One pipeline cycle: present ID, check combinational then registered outputs
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic redir);
        logic       e_stall;
        logic       bub;
        logic [2:0] c1;
        logic [2:0] c2;
        id_valid    = v;
        id_op       = op;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = rd;
        ex_redirect = redir;
        #1;
        e_stall = v && m_ex.ld && m_ex.wen && !redir &&
                  ((uses1(op) && r1 == m_ex.rd) || (uses2(op) && r2 == m_ex.rd));
        obs_stall = stall;
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(redir));
        c1  = fwd_code(op, r1, r2, m_ex, 3'd1);
        c2  = fwd_code(op, r1, r2, m_mem, 3'd3);
        bub = e_stall || redir || !v;
        if (bub) begin
            c1 = 3'd0;
            c2 = 3'd0;
        end
        if (e_stall && m_cnt < 3) m_cnt++;
        @(posedge clk);
        #1;
        chk("hazard_reg1", 32'(hazard_reg1), 32'(c1));
        chk("is_hazard1", 32'(is_hazard1), 32'(c1 != 3'd0));
        chk("hazard_reg2", 32'(hazard_reg2), 32'(c2));
        chk("is_hazard2", 32'(is_hazard2), 32'(c2 != 3'd0));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
        m_mem   = m_ex;
        m_ex    = bub ? slot_t'(0) : slot_t'{rd, writes(op, rd), op == LOAD};
        m_stall = e_stall;
    endtask

    task automatic model_reset();
        m_ex    = slot_t'(0);
        m_mem   = slot_t'(0);
        m_cnt   = 0;
        m_stall = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_reg1"}, 32'(hazard_reg1), 32'd0);
        chk({tag, "_reg2"}, 32'(hazard_reg2), 32'd0);
        chk({tag, "_hz1"}, 32'(is_hazard1), 32'd0);
        chk({tag, "_hz2"}, 32'(is_hazard2), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    task automatic rand_phase(input int n);
        logic [6:0] ops [10];
        logic [6:0] op;
        logic [4:0] r1, r2, rd;
        logic       v, redir;
        ops = '{LOAD, STORE, BRANCH, JAL, JALR, OP, OPIMM, LUI, AUIPC, BADOP};
        op = OPIMM; r1 = 0; r2 = 0; rd = 0; v = 0;
        for (int i = 0; i < n; i++) begin
            // A stalled instruction stays in ID and is presented again
            if (!m_stall) begin
                op = ops[$urandom_range(0, 9)];
                r1 = 5'($urandom_range(0, 3));
                r2 = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
                v  = ($urandom_range(0, 99) < 85);
            end
            redir = ($urandom_range(0, 99) < 10);
            step(v, op, r1, r2, rd, redir);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_op = OPIMM; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_redirect = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        ex_redirect = 1'b1;
        #1;
        chk("rst_flush", 32'(flush), 32'd1);
        ex_redirect = 1'b0;
        rst_n = 1'b1;

        // add x5,x1,x2 ; sub x6,x5,x3
        step(1, OP, 1, 2, 5, 0);
        step(1, OP, 5, 3, 6, 0);
        chk("add_sub_reg1", 32'(hazard_reg1), 32'd1);
        chk("add_sub_hz1", 32'(is_hazard1), 32'd1);
        chk("add_sub_stall", 32'(obs_stall), 32'd0);

        // add x5 ; nop ; or x7,x4,x5
        step(1, OP, 1, 2, 5, 0);
        step(1, OPIMM, 0, 0, 0, 0);
        step(1, OP, 4, 5, 7, 0);
        chk("mem_rs2_reg2", 32'(hazard_reg2), 32'd4);
        chk("mem_rs2_hz2", 32'(is_hazard2), 32'd1);
        chk("mem_rs2_reg1", 32'(hazard_reg1), 32'd0);

        // lw x8,0(x1) ; add x9,x8,x2 -> one stall, bubble, then MEM code 3
        step(1, LOAD, 1, 0, 8, 0);
        step(1, OP, 8, 2, 9, 0);
        chk("lu_stall", 32'(obs_stall), 32'd1);
        chk("lu_bubble", 32'(hazard_reg1), 32'd0);
        step(1, OP, 8, 2, 9, 0);
        chk("lu_stall_end", 32'(obs_stall), 32'd0);
        chk("lu_reg2", 32'(hazard_reg2), 32'd3);

        // lw x8 ; beq x8,x0 with redirect in the same cycle
        step(1, LOAD, 1, 0, 8, 0);
        step(1, BRANCH, 8, 0, 0, 1);
        chk("redir_stall", 32'(obs_stall), 32'd0);
        chk("redir_bubble", 32'(hazard_reg1), 32'd0);
        step(1, OP, 8, 8, 10, 0);
        chk("redir_after", 32'(hazard_reg1), 32'd0);

        // x0 is never a hazard; unused source fields are ignored
        step(1, OPIMM, 0, 0, 0, 0);
        step(1, OP, 0, 0, 1, 0);
        chk("x0_reg1", 32'(hazard_reg1), 32'd0);
        chk("x0_reg2", 32'(hazard_reg2), 32'd0);
        step(1, LUI, 0, 0, 3, 0);
        step(1, OP, 3, 0, 3, 0);
        chk("lui_reg1", 32'(hazard_reg1), 32'd1);
        step(1, LUI, 0, 0, 3, 0);
        step(1, JAL, 3, 3, 5, 0);
        chk("jal_nosrc", 32'(hazard_reg1), 32'd0);

        // Four load-use stalls saturate a 2-bit counter
        for (int i = 0; i < 4; i++) begin
            step(1, LOAD, 1, 0, 8, 0);
            step(1, OP, 2, 8, 9, 0);
            step(1, OP, 2, 8, 9, 0);
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_sat", 32'(stall_cnt), 32'd3);
`endif

        rand_phase(400);

        // Reset asserted while a load-use stall is pending
        step(1, LOAD, 1, 0, 8, 0);
        id_valid = 1; id_op = OP; id_rs1 = 8; id_rs2 = 2; id_rd = 9; ex_redirect = 0;
        #1;
        chk("mid_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, OP, 8, 2, 9, 0);
        chk("post_rst_stall", 32'(obs_stall), 32'd0);

        rand_phase(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
